// File: rtl/des_arb_ctrl.sv
// Two-requester round-robin front end for one shared DES core.
// One job in flight: grant in IDLE, count LATENCY cycles in WAIT, hold the result in RESP.
module des_arb_ctrl #(
    parameter int unsigned LATENCY = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_key,
    input  logic [63:0] req0_text,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_key,
    input  logic [63:0] req1_text,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_text,
    output logic        rsp_id,
    output logic [63:0] core_key,
    output logic [63:0] core_text,
    input  logic [63:0] core_result,
    output logic        busy
);

    localparam logic [7:0] CntLoad = 8'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        r_last_grant;
    logic        r_rsp_id;
    logic [63:0] r_key, r_text, r_rsp_text;
    logic        w_idle, w_grant0, w_grant1, w_capture, w_done;

    assign w_idle = (r_state == StIdle);

    // On a tie the requester that was not granted last wins.
    assign w_grant0  = w_idle & req0_valid & (~req1_valid | r_last_grant);
    assign w_grant1  = w_idle & req1_valid & (~req0_valid | ~r_last_grant);
    assign w_capture = w_grant0 | w_grant1;
    assign w_done    = (r_state == StWait) && (r_cnt == 8'd0);

    // Readys are gated by reset so every output is low while reset is held.
    assign req0_ready = rst_n & w_grant0;
    assign req1_ready = rst_n & w_grant1;
    assign rsp_valid  = (r_state == StResp);
    assign busy       = ~w_idle;
    assign rsp_text   = r_rsp_text;
    assign rsp_id     = r_rsp_id;
    assign core_key   = r_key;
    assign core_text  = r_text;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_capture) begin
                    w_state_nxt = StWait;
                    w_cnt_nxt   = CntLoad;
                end
            end
            StWait: begin
                if (r_cnt == 8'd0) begin
                    w_state_nxt = StResp;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_cnt        <= 8'd0;
            r_last_grant <= 1'b1;
            r_key        <= 64'd0;
            r_text       <= 64'd0;
            r_rsp_text   <= 64'd0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_key        <= w_grant1 ? req1_key : req0_key;
                r_text       <= w_grant1 ? req1_text : req0_text;
                r_last_grant <= w_grant1;
            end
            // The in-flight job id is always the last grant.
            if (w_done) begin
                r_rsp_text <= core_result;
                r_rsp_id   <= r_last_grant;
            end
        end
    end

endmodule

// File: tb/tb_des_arb_ctrl.sv
// Randomized scoreboard bench for des_arb_ctrl with a latency-aware stand-in for the DES core.
// A second instance with LATENCY=1 checks the shortest job period.
module tb_des_arb_ctrl;

    localparam int unsigned LAT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [63:0] req0_key, req0_text, req1_key, req1_text;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [63:0] rsp_text, core_key, core_text, core_result;

    logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
    logic [63:0] b_req0_key, b_req0_text, b_req1_key, b_req1_text;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;
    logic [63:0] b_rsp_text, b_core_key, b_core_text, b_core_result;

    des_arb_ctrl #(.LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_key(req0_key), .req0_text(req0_text),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_key(req1_key), .req1_text(req1_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text), .rsp_id(rsp_id),
        .core_key(core_key), .core_text(core_text), .core_result(core_result), .busy(busy)
    );

    des_arb_ctrl #(.LATENCY(1)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready),
        .req0_key(b_req0_key), .req0_text(b_req0_text),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready),
        .req1_key(b_req1_key), .req1_text(b_req1_text),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_text(b_rsp_text),
        .rsp_id(b_rsp_id), .core_key(b_core_key), .core_text(b_core_text),
        .core_result(b_core_result), .busy(b_busy)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] fmix(input logic [63:0] k, input logic [63:0] t);
        return {k[31:0] ^ t[63:32], k[63:32] + t[31:0]} ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    // Core stand-in: the answer is only correct once its inputs have been stable LAT cycles.
    int age = 0;
    logic [63:0] pk = 64'd0, pt = 64'd0;
    always @(negedge clk) begin
        if (core_key !== pk || core_text !== pt) age = 1;
        else if (age < 1000) age = age + 1;
        pk = core_key;
        pt = core_text;
    end
    assign core_result   = (age >= int'(LAT)) ? fmix(core_key, core_text)
                                              : ~fmix(core_key, core_text);
    assign b_core_result = fmix(b_core_key, b_core_text);

    typedef struct {
        logic        id;
        logic [63:0] text;
        int          due;
    } exp_t;

    exp_t  sb_q[$];
    logic  dut_log[$];
    logic  m_last = 1'b1;
    int    last_xfer = -1;
    int    n_grants = 0;
    bit    run_chk = 0;
    logic [63:0] last_text = 64'd0;
    logic  last_id = 1'b0;

    // Reference model: one job at a time, round robin on ties, response LAT+1 cycles later.
    always @(negedge clk) begin : model
        logic idle, g0, g1;
        exp_t e;
        if (rst_n && run_chk) begin
            idle = (sb_q.size() == 0) && (cyc > last_xfer);
            g0 = idle && req0_valid && (!req1_valid || m_last);
            g1 = idle && req1_valid && (!req0_valid || !m_last);
            check("req0_ready", 64'(req0_ready), 64'(g0));
            check("req1_ready", 64'(req1_ready), 64'(g1));
            check("busy", 64'(busy), 64'(!idle));
            if (req0_valid && req0_ready) dut_log.push_back(1'b0);
            if (req1_valid && req1_ready) dut_log.push_back(1'b1);
            if (g0 || g1) begin
                e.id   = g1;
                e.text = g1 ? fmix(req1_key, req1_text) : fmix(req0_key, req0_text);
                e.due  = cyc + int'(LAT) + 1;
                sb_q.push_back(e);
                m_last = g1;
                n_grants++;
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t h;
        logic exp_valid;
        if (rst_n && run_chk) begin
            if (sb_q.size() == 0) begin
                check("rsp_valid idle", 64'(rsp_valid), 64'(0));
                check("rsp_text hold", rsp_text, last_text);
                check("rsp_id hold", 64'(rsp_id), 64'(last_id));
            end else begin
                h = sb_q[0];
                exp_valid = (cyc >= h.due);
                check("rsp_valid timing", 64'(rsp_valid), 64'(exp_valid));
                if (exp_valid) begin
                    check("rsp_text", rsp_text, h.text);
                    check("rsp_id", 64'(rsp_id), 64'(h.id));
                    if (rsp_valid && rsp_ready) begin
                        void'(sb_q.pop_front());
                        last_xfer = cyc;
                        last_text = h.text;
                        last_id   = h.id;
                    end
                end else begin
                    check("rsp_text before result", rsp_text, last_text);
                end
            end
        end
    end

    exp_t qb[$];
    bit   run_b = 0;
    int   last_hs_b = -1;
    int   n_hs_b = 0;

    always @(negedge clk) begin : mon_b
        exp_t e;
        logic exp_valid;
        if (rst_n && run_b) begin
            if (b_req0_valid && b_req0_ready) begin
                if (last_hs_b >= 0) check("lat1 job period", 64'(cyc - last_hs_b), 64'(3));
                last_hs_b = cyc;
                n_hs_b++;
                e.id   = 1'b0;
                e.text = fmix(b_req0_key, b_req0_text);
                e.due  = cyc + 2;
                qb.push_back(e);
            end
            if (qb.size() == 0) begin
                check("lat1 rsp_valid idle", 64'(b_rsp_valid), 64'(0));
            end else begin
                exp_valid = (cyc >= qb[0].due);
                check("lat1 rsp_valid timing", 64'(b_rsp_valid), 64'(exp_valid));
                if (exp_valid) begin
                    check("lat1 rsp_text", b_rsp_text, qb[0].text);
                    if (b_rsp_valid && b_rsp_ready) void'(qb.pop_front());
                end
            end
        end
    end

    task automatic wait_grants(input int target);
        int i;
        i = 0;
        while (n_grants < target && i < 300) begin
            @(posedge clk);
            i++;
        end
        check("grant wait", 64'(n_grants >= target), 64'(1));
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (sb_q.size() != 0 && i < 600) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("drain", 64'(sb_q.size()), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req0_ready"}, 64'(req0_ready), 64'(0));
        check({tag, " req1_ready"}, 64'(req1_ready), 64'(0));
        check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(0));
        check({tag, " rsp_text"}, rsp_text, 64'(0));
        check({tag, " rsp_id"}, 64'(rsp_id), 64'(0));
        check({tag, " core_key"}, core_key, 64'(0));
        check({tag, " core_text"}, core_text, 64'(0));
        check({tag, " busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        int g;
        int i;
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_key = '0; req0_text = '0; req1_key = '0; req1_text = '0;
        b_req0_valid = 0; b_req1_valid = 0; b_rsp_ready = 1;
        b_req0_key = '0; b_req0_text = '0; b_req1_key = '0; b_req1_text = '0;

        repeat (3) @(posedge clk);
        #1;
        // Both requesters valid during reset must not be acknowledged.
        req0_valid = 1; req1_valid = 1;
        #1;
        check_all_zero("reset");
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        last_xfer = cyc - 1;
        run_chk = 1;

        // Contention straight after reset.
        req0_key = {$urandom, $urandom}; req0_text = {$urandom, $urandom};
        req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
        req0_valid = 1; req1_valid = 1;
        wait_grants(4);
        #1;
        req0_valid = 0; req1_valid = 0;
        wait_drain();
        check("contention grants", 64'(dut_log.size() >= 4), 64'(1));
        if (dut_log.size() >= 4)
            for (int k = 0; k < 4; k++) check("grant order", 64'(dut_log[k]), 64'(k % 2));

        // Single job with the reference DES vector.
        req0_key = 64'h1334_5779_9BBC_DFF1; req0_text = 64'h0123_4567_89AB_CDEF;
        req0_valid = 1;
        wait_grants(n_grants + 1);
        #1;
        req0_valid = 0;
        wait_drain();

        // Backpressure with a competing requester waiting.
        rsp_ready = 0;
        req0_key = {$urandom, $urandom}; req0_text = {$urandom, $urandom};
        req0_valid = 1;
        wait_grants(n_grants + 1);
        #1;
        req0_valid = 0;
        req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
        req1_valid = 1;
        g = n_grants;
        i = 0;
        while (!rsp_valid && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        check("bp rsp_valid seen", 64'(rsp_valid), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        rsp_ready = 1;
        wait_grants(g + 1);
        #1;
        req1_valid = 0;
        wait_drain();

        // Random traffic: short valid pulses, random data, random backpressure.
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            req0_valid = ($urandom_range(0, 2) == 0);
            req1_valid = ($urandom_range(0, 2) == 0);
            req0_key = {$urandom, $urandom}; req0_text = {$urandom, $urandom};
            req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        wait_drain();

        // Reset in the middle of WAIT, then a fresh req1 job.
        req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
        req1_valid = 1;
        wait_grants(n_grants + 1);
        #1;
        req1_valid = 0;
        repeat (7) @(posedge clk);
        #2;
        run_chk = 0;
        rst_n = 0;
        #1;
        check_all_zero("mid-wait reset");
        sb_q.delete();
        m_last = 1'b1;
        last_text = 64'd0;
        last_id = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        last_xfer = cyc - 1;
        run_chk = 1;
        repeat (4) @(posedge clk);
        #1;
        req1_key = {$urandom, $urandom}; req1_text = {$urandom, $urandom};
        req1_valid = 1;
        wait_grants(n_grants + 1);
        #1;
        req1_valid = 0;
        wait_drain();

        // LATENCY=1 instance: back-to-back req0 jobs, data changing every cycle.
        run_b = 1;
        b_req0_valid = 1;
        for (int k = 0; k < 21; k++) begin
            b_req0_key = {$urandom, $urandom};
            b_req0_text = {$urandom, $urandom};
            @(posedge clk);
            #1;
        end
        b_req0_valid = 0;
        repeat (5) @(posedge clk);
        #1;
        check("lat1 job count", 64'(n_hs_b), 64'(7));
        check("lat1 drained", 64'(qb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/des_arb_ctrl.md
DES_ARB_CTRL -- requirements
Module: des_arb_ctrl

Interface
REQ-001 The block SHALL have parameter LATENCY, default 16, meaning the number of clock cycles from a core input update to a valid core_result; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have ports req0_valid (input, 1 bit), req0_ready (output, 1 bit), req0_key (input, 64 bits) and req0_text (input, 64 bits): requester 0 job channel.
REQ-005 The block SHALL have ports req1_valid (input, 1 bit), req1_ready (output, 1 bit), req1_key (input, 64 bits) and req1_text (input, 64 bits): requester 1 job channel.
REQ-006 The block SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_text (output, 64 bits) and rsp_id (output, 1 bit): result channel; rsp_id is the index of the originating requester.
REQ-007 The block SHALL have ports core_key (output, 64 bits) and core_text (output, 64 bits) driving cipher_key/plain_text of the shared des_top, plus core_result (input, 64 bits) taken from its cipher_text.
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 The block SHALL implement FSM states IDLE, WAIT and RESP, with only one job in flight.
REQ-010 In IDLE the block SHALL assert at most one reqN_ready, for the requester granted this cycle; it SHALL not assert any ready in WAIT or RESP.
REQ-011 Grant: one valid only -> that requester; both valid -> requester != last_grant (round robin); none valid -> no grant, no ready.
REQ-012 Handshake reqN_valid&reqN_ready at cycle T SHALL capture reqN_key/reqN_text into core_key/core_text, record N as job id and last_grant, load cnt=LATENCY-1 and move to WAIT, all at the end of T.
REQ-013 core_key/core_text SHALL stay stable from capture until the next capture, including through RESP and IDLE.
REQ-014 In WAIT cnt SHALL decrement each cycle; in the cycle where cnt==0 the block SHALL latch core_result into rsp_text and move to RESP, so rsp_valid rises at cycle T+LATENCY+1.
REQ-015 In RESP rsp_valid SHALL be 1 with rsp_text/rsp_id stable until rsp_valid&rsp_ready; it SHALL then move to IDLE with rsp_valid=0 next cycle.
REQ-016 rsp_text and rsp_id SHALL hold their last value after the transfer.
REQ-017 A valid dropped by a requester before its handshake SHALL not be captured; requester valid/data changes during WAIT/RESP SHALL have no effect.
REQ-018 Minimum job period with rsp_ready tied high SHALL be LATENCY+2 cycles (IDLE grant, LATENCY WAIT cycles, RESP).

Reset
REQ-019 rst_n=0 SHALL asynchronously force state IDLE, cnt=0, last_grant=1 (req0 wins first tie), and all outputs to 0: req0_ready, req1_ready, rsp_valid, rsp_text, rsp_id, core_key, core_text and busy.
REQ-020 Reset asserted in WAIT or RESP SHALL abandon the job with no response; after release, operation SHALL resume from IDLE normally.

Verification
REQ-021 Single job: req0 key 133457799BBCDFF1, text 0123456789ABCDEF, LATENCY=16 -> rsp_valid at T+17, rsp_text 85E813540F0AB405, rsp_id 0.
REQ-022 Contention: both valid continuously after reset -> grant order 0,1,0,1; each rsp_id matches its grant; no grant while busy.
REQ-023 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_text and rsp_id held; no new ready until one cycle after the transfer.
REQ-024 Reset mid-WAIT (cnt=8) -> outputs 0 immediately; no rsp_valid; a new req1 job after release completes correctly.
REQ-025 LATENCY=1 -> rsp_valid at T+2; back-to-back req0 jobs with rsp_ready high complete every 3 cycles.
REQ-026 A valid pulse dropped before its grant (other requester busy) -> no capture and no response for it.
